// File: rtl/retro_vending_multi.sv
// Multi-item coin vending controller: accumulates credit, vends the current item
// with change, refunds on cancel, and keeps a saturating stock counter per item.
module retro_vending_multi #(
  parameter int                          N_ITEMS    = 4,
  parameter int                          PRICE_W    = 8,
  parameter int                          STOCK_W    = 4,
  parameter int                          INIT_STOCK = 5,
  parameter logic [N_ITEMS*PRICE_W-1:0]  PRICES     = {8'd75, 8'd50, 8'd35, 8'd25},
  parameter int                          MAX_CREDIT = 200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       coin_5,
  input  logic                       coin_10,
  input  logic                       coin_25,
  input  logic                       next_item,
  input  logic                       select,
  input  logic                       cancel,
  input  logic                       restock,
  output logic [$clog2(N_ITEMS)-1:0] item_idx,
  output logic [PRICE_W-1:0]         credit,
  output logic                       dispense,
  output logic [PRICE_W-1:0]         change,
  output logic                       change_valid,
  output logic                       sold_out,
  output logic                       coin_reject
);

  localparam int IDX_W      = $clog2(N_ITEMS);
  localparam int STOCK_MAX  = (1 << STOCK_W) - 1;
  // An oversized INIT_STOCK is clamped so the counters saturate instead of wrapping.
  localparam int STOCK_LOAD = (INIT_STOCK > STOCK_MAX) ? STOCK_MAX : INIT_STOCK;

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, PAYOUT} state_t;

  state_t             state_r;
  logic [STOCK_W-1:0] stock_r [N_ITEMS];

  logic [PRICE_W:0]   coin_sum_s;
  logic [PRICE_W:0]   credit_sum_s;
  logic [PRICE_W-1:0] price_s;
  logic               any_coin_s;
  logic               active_s;
  logic               vend_ok_s;
  logic               cancel_ok_s;
  logic               coin_fits_s;

  // Decode this cycle's candidate actions from registered state and the inputs.
  always_comb begin
    coin_sum_s   = (coin_5  ? (PRICE_W+1)'(5)  : (PRICE_W+1)'(0))
                 + (coin_10 ? (PRICE_W+1)'(10) : (PRICE_W+1)'(0))
                 + (coin_25 ? (PRICE_W+1)'(25) : (PRICE_W+1)'(0));
    credit_sum_s = {1'b0, credit} + coin_sum_s;
    price_s      = PRICES[item_idx*PRICE_W +: PRICE_W];
    any_coin_s   = coin_5 | coin_10 | coin_25;
    active_s     = (state_r == IDLE) || (state_r == CREDIT);
    cancel_ok_s  = cancel && (state_r == CREDIT);
    vend_ok_s    = select && (state_r == CREDIT) && (credit >= price_s)
                   && (stock_r[item_idx] != STOCK_W'(0));
    coin_fits_s  = credit_sum_s <= (PRICE_W+1)'(MAX_CREDIT);
  end

  assign sold_out = (stock_r[item_idx] == STOCK_W'(0));

  // Main controller: state, credit, item pointer, stock and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      credit       <= '0;
      item_idx     <= '0;
      dispense     <= 1'b0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      for (int i = 0; i < N_ITEMS; i++) begin
        stock_r[i] <= STOCK_W'(STOCK_LOAD);
      end
    end else begin
      dispense     <= 1'b0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      case (state_r)
        IDLE, CREDIT: begin
          if (restock && (state_r == IDLE)) begin
            for (int i = 0; i < N_ITEMS; i++) begin
              stock_r[i] <= STOCK_W'(STOCK_LOAD);
            end
          end
          if (cancel_ok_s) begin
            state_r      <= PAYOUT;
            change       <= credit;
            change_valid <= 1'b1;
            credit       <= '0;
            coin_reject  <= any_coin_s;
          end else if (vend_ok_s) begin
            state_r           <= VEND;
            dispense          <= 1'b1;
            change_valid      <= 1'b1;
            change            <= credit - price_s;
            credit            <= '0;
            stock_r[item_idx] <= stock_r[item_idx] - STOCK_W'(1);
            coin_reject       <= any_coin_s;
          end else if (any_coin_s && coin_fits_s) begin
            state_r <= CREDIT;
            credit  <= credit_sum_s[PRICE_W-1:0];
          end else begin
            // A refused coin does not count as an action, so next_item still applies.
            coin_reject <= any_coin_s;
            if (next_item) begin
              item_idx <= (item_idx == IDX_W'(N_ITEMS-1)) ? IDX_W'(0) : item_idx + IDX_W'(1);
            end
          end
        end
        VEND, PAYOUT: begin
          state_r     <= IDLE;
          coin_reject <= any_coin_s;
        end
        default: begin
          state_r <= IDLE;
          credit  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retro_vending_multi.sv
// Table-driven bench for retro_vending_multi; every driven cycle queues its expected
// outputs and the scoreboard compares them just after the following clock edge.
module tb_retro_vending_multi;

  logic       clk = 1'b0;
  logic       reset, coin_5, coin_10, coin_25, next_item, select, cancel, restock;
  logic [1:0] item_idx;
  logic [7:0] credit, change;
  logic       dispense, change_valid, sold_out, coin_reject;

  retro_vending_multi dut (
    .clk(clk), .reset(reset), .coin_5(coin_5), .coin_10(coin_10), .coin_25(coin_25),
    .next_item(next_item), .select(select), .cancel(cancel), .restock(restock),
    .item_idx(item_idx), .credit(credit), .dispense(dispense), .change(change),
    .change_valid(change_valid), .sold_out(sold_out), .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  // Input bits: {reset, restock, cancel, select, next_item, coin_25, coin_10, coin_5}
  localparam logic [7:0] C5 = 8'h01, C10 = 8'h02, C25 = 8'h04, NX = 8'h08;
  localparam logic [7:0] SEL = 8'h10, CAN = 8'h20, RSK = 8'h40, RST = 8'h80, NOP = 8'h00;

  typedef struct {
    logic [7:0] in;
    logic [1:0] idx;
    logic [7:0] cr;
    logic       disp;
    logic [7:0] chg;
    logic       cv;
    logic       so;
    logic       rej;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   vec_no = 0;

  function automatic vec_t mk(logic [7:0] in, logic [1:0] idx, logic [7:0] cr, logic disp,
                              logic [7:0] chg, logic cv, logic so, logic rej);
    vec_t v;
    v.in = in; v.idx = idx; v.cr = cr; v.disp = disp;
    v.chg = chg; v.cv = cv; v.so = so; v.rej = rej;
    return v;
  endfunction

  task automatic check_next();
    vec_t e;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_empty vec%0d: no expected entry queued", vec_no);
    end else begin
      e = exp_q.pop_front();
      tests++;
      if ({item_idx, credit, dispense, change, change_valid, sold_out, coin_reject} !==
          {e.idx, e.cr, e.disp, e.chg, e.cv, e.so, e.rej}) begin
        fails++;
        $display("FAIL vec%0d: got idx=%0d cr=%0d disp=%b chg=%0d cv=%b so=%b rej=%b, want idx=%0d cr=%0d disp=%b chg=%0d cv=%b so=%b rej=%b",
                 vec_no, item_idx, credit, dispense, change, change_valid, sold_out, coin_reject,
                 e.idx, e.cr, e.disp, e.chg, e.cv, e.so, e.rej);
      end
    end
    vec_no++;
  endtask

  task automatic drive(vec_t v);
    @(negedge clk);
    {reset, restock, cancel, select, next_item, coin_25, coin_10, coin_5} = v.in;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_next();
  endtask

  initial begin
    {reset, restock, cancel, select, next_item, coin_25, coin_10, coin_5} = 8'h00;

    //                 in         idx   cr     disp  chg    cv    so    rej
    tbl.push_back(mk(RST,       2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    // single coin then vend of item 0 with exact money
    tbl.push_back(mk(C25,       2'd0, 8'd25, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(SEL,       2'd0, 8'd0,  1'b1, 8'd0,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NOP,       2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    // 50 credit, item 1 (35) -> change 15
    tbl.push_back(mk(C25,       2'd0, 8'd25, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(C25,       2'd0, 8'd50, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(NX,        2'd1, 8'd50, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(SEL,       2'd1, 8'd0,  1'b1, 8'd15, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NOP,       2'd1, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    // insufficient credit on item 2, then refund
    tbl.push_back(mk(NX,        2'd2, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(C10,       2'd2, 8'd10, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(SEL,       2'd2, 8'd10, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(CAN,       2'd2, 8'd0,  1'b0, 8'd10, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NOP,       2'd2, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    // cancel and select in IDLE do nothing; pointer wraps 3 -> 0
    tbl.push_back(mk(CAN,       2'd2, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(SEL,       2'd2, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(NX,        2'd3, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(NX,        2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    // coin with winning select is refused; coin during VEND is refused
    tbl.push_back(mk(C25,       2'd0, 8'd25, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(SEL | C5,  2'd0, 8'd0,  1'b1, 8'd0,  1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(C10,       2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(NOP,       2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    // coin with winning cancel is refused; coin during PAYOUT is refused
    tbl.push_back(mk(C10,       2'd0, 8'd10, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(CAN | C25, 2'd0, 8'd0,  1'b0, 8'd10, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(C5,        2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(NOP,       2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    // simultaneous coins are summed; coins beat next_item
    tbl.push_back(mk(C5|C10|C25,2'd0, 8'd40, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(C5 | NX,   2'd0, 8'd45, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(CAN,       2'd0, 8'd0,  1'b0, 8'd45, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NOP,       2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    // reset discards credit without a change pulse, even against cancel
    tbl.push_back(mk(NX,        2'd1, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(C25,       2'd1, 8'd25, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(C5,        2'd1, 8'd30, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(RST | CAN, 2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    // next_item is ignored while the vend is in flight
    tbl.push_back(mk(C25,       2'd0, 8'd25, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(SEL | NX,  2'd0, 8'd0,  1'b1, 8'd0,  1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(NX,        2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(NOP,       2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
    end

    // Sold-out sequence: from a fresh reset, five vends empty item 0.
    drive(mk(RST, 2'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    for (int n = 1; n <= 5; n++) begin
      drive(mk(C25, 2'd0, 8'd25, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
      drive(mk(SEL, 2'd0, 8'd0,  1'b1, 8'd0, 1'b1, (n == 5), 1'b0));
      drive(mk(NOP, 2'd0, 8'd0,  1'b0, 8'd0, 1'b0, (n == 5), 1'b0));
    end
    drive(mk(C25, 2'd0, 8'd25, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0));
    drive(mk(SEL, 2'd0, 8'd25, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0));
    drive(mk(RSK, 2'd0, 8'd25, 1'b0, 8'd0,  1'b0, 1'b1, 1'b0));
    drive(mk(CAN, 2'd0, 8'd0,  1'b0, 8'd25, 1'b1, 1'b1, 1'b0));
    drive(mk(RSK, 2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b1, 1'b0));
    drive(mk(RSK, 2'd0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0));

    // Credit ceiling: build 190, overflow is refused, exactly 200 is accepted.
    for (int n = 1; n <= 7; n++) begin
      drive(mk(C25, 2'd0, 8'(25 * n), 1'b0, 8'd0, 1'b0, 1'b0, 1'b0));
    end
    drive(mk(C10,      2'd0, 8'd185, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0));
    drive(mk(C5,       2'd0, 8'd190, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0));
    drive(mk(C25,      2'd0, 8'd190, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1));
    drive(mk(C10,      2'd0, 8'd200, 1'b0, 8'd0,   1'b0, 1'b0, 1'b0));
    drive(mk(C5,       2'd0, 8'd200, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1));
    drive(mk(C5 | SEL, 2'd0, 8'd0,   1'b1, 8'd175, 1'b1, 1'b0, 1'b1));
    drive(mk(NOP,      2'd0, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0));

    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
